fir_sequencer: RTL and testbench

Phase sequencer for the FIR accelerator's datapath: after a start command it clears the datapath and tap buffer, has the streamer load the taps, then streams `x` samples in and `y` results out. It counts output handshakes and signals completion. It sits between the HWPE control slave, the streamer and the tap buffer/datapath. It issues only start/clear pulses and never touches stream data.

---
 rtl/fir_sequencer.sv | 154 +++++++++++++++
 tb/tb_fir_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fir_sequencer.sv
// Phase sequencer for the FIR accelerator: clear -> tap load -> stream run -> drain -> done.
// Optional watchdog enabled by defining FIR_SEQ_TIMEOUT_EN (err_o tied low otherwise).
module fir_sequencer #(
    parameter int unsigned NB_TAPS        = 50,
    parameter int unsigned CNT_WIDTH      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 start_i,
    input  logic [CNT_WIDTH-1:0] nb_samples_i,
    output logic                 dp_clear_o,
    output logic                 h_start_o,
    output logic                 x_start_o,
    output logic                 y_start_o,
    input  logic                 taps_ready_i,
    input  logic                 y_valid_i,
    input  logic                 y_ready_i,
    input  logic                 y_done_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [CNT_WIDTH-1:0] sample_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_LOAD, S_RUN, S_DRAIN, S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic                 first_q, first_d;
    logic [CNT_WIDTH-1:0] n_q, n_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 y_hs;
    logic                 cnt_inc;

    assign y_hs = y_valid_i & y_ready_i;

`ifdef FIR_SEQ_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;
    logic            wd_active;
`endif

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        cnt_inc = 1'b0;
`ifdef FIR_SEQ_TIMEOUT_EN
        err_d     = err_q;
        wd_d      = wd_q;
        wd_active = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_DRAIN);
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_CLEAR;
                    n_d     = nb_samples_i;
                    cnt_d   = '0;
`ifdef FIR_SEQ_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            S_CLEAR: state_d = (n_q == '0) ? S_DONE : S_LOAD;
            S_LOAD: begin
                if (taps_ready_i) state_d = S_RUN;
            end
            S_RUN: begin
                if (y_hs) begin
                    cnt_inc = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_d == n_q) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (y_done_i) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

`ifdef FIR_SEQ_TIMEOUT_EN
        // Expiry overrides any regular transition taken in the same cycle.
        if (wd_active && (wd_q == WD_W'(TIMEOUT_CYCLES - 1))) begin
            state_d = S_DONE;
            err_d   = 1'b1;
        end
        if (!wd_active || (state_d != state_q) || cnt_inc) wd_d = '0;
        else                                                wd_d = wd_q + 1'b1;
`endif

        if (clear_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
`ifdef FIR_SEQ_TIMEOUT_EN
            wd_d    = '0;
            err_d   = 1'b0;
`endif
        end

        first_d = (state_d != state_q);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            first_q <= 1'b0;
            n_q     <= '0;
            cnt_q   <= '0;
`ifdef FIR_SEQ_TIMEOUT_EN
            wd_q    <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
`ifdef FIR_SEQ_TIMEOUT_EN
            wd_q    <= wd_d;
            err_q   <= err_d;
`endif
        end
    end

    // first_q marks the first cycle spent in the current state.
    assign dp_clear_o   = (state_q == S_CLEAR);
    assign h_start_o    = (state_q == S_LOAD) && first_q;
    assign x_start_o    = (state_q == S_RUN) && first_q;
    assign y_start_o    = (state_q == S_RUN) && first_q;
    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = (state_q == S_DONE);
    assign sample_cnt_o = cnt_q;
`ifdef FIR_SEQ_TIMEOUT_EN
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    if (NB_TAPS < 1) begin : g_bad_taps
        $error("fir_sequencer: NB_TAPS must be at least 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("fir_sequencer: TIMEOUT_CYCLES must be at least 1");
    end

    a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q != S_IDLE) |-> (cnt_q <= n_q));

endmodule

// File: tb/tb_fir_sequencer.sv
// Directed bench for fir_sequencer: cycle table plus hand-written long-job and reset sequences.
module tb_fir_sequencer;

    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_ni, clear_i, start_i;
    logic [CW-1:0] nb_samples_i;
    logic          dp_clear_o, h_start_o, x_start_o, y_start_o;
    logic          taps_ready_i, y_valid_i, y_ready_i, y_done_i;
    logic          busy_o, done_o, err_o;
    logic [CW-1:0] sample_cnt_o;

    int n_checks = 0;
    int n_err    = 0;
    int c_dc = 0, c_h = 0, c_x = 0, c_y = 0, c_dn = 0;

    always #5 clk = ~clk;

    fir_sequencer #(.NB_TAPS(50), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(1024)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
        .nb_samples_i(nb_samples_i), .dp_clear_o(dp_clear_o), .h_start_o(h_start_o),
        .x_start_o(x_start_o), .y_start_o(y_start_o), .taps_ready_i(taps_ready_i),
        .y_valid_i(y_valid_i), .y_ready_i(y_ready_i), .y_done_i(y_done_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .sample_cnt_o(sample_cnt_o)
    );

    always @(posedge clk) begin
        if (dp_clear_o) c_dc++;
        if (h_start_o)  c_h++;
        if (x_start_o)  c_x++;
        if (y_start_o)  c_y++;
        if (done_o)     c_dn++;
    end

    typedef struct {
        logic st, clr, tp, yv, yr, yd;
        logic [CW-1:0] nb;
        logic e_dc, e_h, e_x, e_y, e_bs, e_dn;
        logic [CW-1:0] e_cnt;
    } vec_t;

    vec_t vecs[36];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] flags();
        return {dp_clear_o, h_start_o, x_start_o, y_start_o, busy_o, done_o, err_o};
    endfunction

    task automatic idle_inputs();
        clear_i = 0; start_i = 0; taps_ready_i = 0;
        y_valid_i = 0; y_ready_i = 0; y_done_i = 0; nb_samples_i = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int s_dc, s_h, s_x, s_y, s_dn;
        // Each row: inputs sampled this cycle -> outputs seen the following cycle.
        //            st clr tp yv yr yd nb   | dc h  x  y  bs dn cnt
        vecs[0]  = '{1, 0, 0, 0, 0, 0, 0,     1, 0, 0, 0, 1, 0, 0};
        vecs[1]  = '{0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 1, 1, 0};
        vecs[2]  = '{0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0};
        vecs[3]  = '{1, 0, 0, 0, 0, 0, 4,     1, 0, 0, 0, 1, 0, 0};
        vecs[4]  = '{0, 0, 0, 1, 1, 0, 0,     0, 1, 0, 0, 1, 0, 0};
        vecs[5]  = '{0, 0, 0, 1, 1, 0, 0,     0, 0, 0, 0, 1, 0, 0};
        vecs[6]  = '{0, 0, 1, 1, 1, 0, 0,     0, 0, 1, 1, 1, 0, 0};
        vecs[7]  = '{0, 0, 0, 1, 1, 0, 0,     0, 0, 0, 0, 1, 0, 1};
        vecs[8]  = '{0, 0, 0, 1, 0, 0, 0,     0, 0, 0, 0, 1, 0, 1};
        vecs[9]  = '{1, 0, 0, 1, 1, 0, 9,     0, 0, 0, 0, 1, 0, 2};
        vecs[10] = '{0, 0, 0, 1, 0, 1, 0,     0, 0, 0, 0, 1, 0, 2};
        vecs[11] = '{0, 0, 0, 1, 1, 0, 0,     0, 0, 0, 0, 1, 0, 3};
        vecs[12] = '{0, 0, 0, 1, 0, 0, 0,     0, 0, 0, 0, 1, 0, 3};
        vecs[13] = '{0, 0, 0, 1, 1, 0, 0,     0, 0, 0, 0, 1, 0, 4};
        vecs[14] = '{1, 0, 0, 1, 1, 0, 9,     0, 0, 0, 0, 1, 0, 4};
        vecs[15] = '{0, 0, 0, 0, 0, 1, 0,     0, 0, 0, 0, 1, 1, 4};
        vecs[16] = '{0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 4};
        vecs[17] = '{1, 0, 0, 0, 0, 0, 5,     1, 0, 0, 0, 1, 0, 0};
        vecs[18] = '{0, 0, 1, 0, 0, 0, 0,     0, 1, 0, 0, 1, 0, 0};
        vecs[19] = '{0, 0, 1, 0, 0, 0, 0,     0, 0, 1, 1, 1, 0, 0};
        vecs[20] = '{0, 0, 0, 1, 1, 0, 0,     0, 0, 0, 0, 1, 0, 1};
        vecs[21] = '{0, 0, 0, 1, 1, 0, 0,     0, 0, 0, 0, 1, 0, 2};
        vecs[22] = '{0, 1, 0, 1, 1, 0, 0,     0, 0, 0, 0, 0, 0, 0};
        vecs[23] = '{0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0};
        vecs[24] = '{1, 0, 0, 0, 0, 0, 3,     1, 0, 0, 0, 1, 0, 0};
        vecs[25] = '{0, 0, 1, 0, 0, 0, 0,     0, 1, 0, 0, 1, 0, 0};
        vecs[26] = '{0, 0, 1, 0, 0, 0, 0,     0, 0, 1, 1, 1, 0, 0};
        vecs[27] = '{0, 0, 0, 1, 1, 0, 0,     0, 0, 0, 0, 1, 0, 1};
        vecs[28] = '{0, 0, 0, 1, 1, 0, 0,     0, 0, 0, 0, 1, 0, 2};
        vecs[29] = '{0, 0, 0, 1, 1, 0, 0,     0, 0, 0, 0, 1, 0, 3};
        vecs[30] = '{0, 0, 0, 0, 0, 1, 0,     0, 0, 0, 0, 1, 1, 3};
        vecs[31] = '{0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 3};
        vecs[32] = '{1, 1, 0, 0, 0, 0, 7,     0, 0, 0, 0, 0, 0, 0};
        vecs[33] = '{1, 0, 0, 0, 0, 0, 2,     1, 0, 0, 0, 1, 0, 0};
        vecs[34] = '{0, 1, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0};
        vecs[35] = '{0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0};

        rst_ni = 0;
        idle_inputs();
        cyc(); cyc();
        check("reset.flags", 32'(flags()), 32'h0);
        check("reset.cnt", 32'(sample_cnt_o), 32'h0);
        rst_ni = 1;
        cyc();

        for (int i = 0; i < 36; i++) begin
            start_i = vecs[i].st; clear_i = vecs[i].clr; taps_ready_i = vecs[i].tp;
            y_valid_i = vecs[i].yv; y_ready_i = vecs[i].yr; y_done_i = vecs[i].yd;
            nb_samples_i = vecs[i].nb;
            cyc();
            check($sformatf("vec%0d.flags", i), 32'(flags()),
                  32'({vecs[i].e_dc, vecs[i].e_h, vecs[i].e_x, vecs[i].e_y,
                       vecs[i].e_bs, vecs[i].e_dn, 1'b0}));
            check($sformatf("vec%0d.cnt", i), 32'(sample_cnt_o), 32'(vecs[i].e_cnt));
        end
        idle_inputs();
        cyc();

        // Normal job: 8 samples, taps ready 50 cycles after h_start.
        s_dc = c_dc; s_h = c_h; s_x = c_x; s_y = c_y; s_dn = c_dn;
        nb_samples_i = 8; start_i = 1;
        cyc();
        start_i = 0; nb_samples_i = '0;
        check("norm.clear", 32'(dp_clear_o), 32'h1);
        cyc();
        check("norm.h_start", 32'(h_start_o), 32'h1);
        repeat (50) cyc();
        check("norm.load_wait", 32'({busy_o, h_start_o, x_start_o}), 32'b100);
        taps_ready_i = 1;
        cyc();
        taps_ready_i = 0;
        check("norm.run_start", 32'({x_start_o, y_start_o}), 32'b11);
        y_valid_i = 1; y_ready_i = 1;
        repeat (8) cyc();
        y_valid_i = 0; y_ready_i = 0;
        check("norm.drain_cnt", 32'(sample_cnt_o), 32'd8);
        check("norm.drain_busy", 32'({busy_o, done_o}), 32'b10);
        repeat (2) cyc();
        y_done_i = 1;
        cyc();
        y_done_i = 0;
        check("norm.done", 32'({busy_o, done_o}), 32'b11);
        cyc();
        check("norm.idle", 32'({busy_o, done_o}), 32'b00);
        check("norm.final_cnt", 32'(sample_cnt_o), 32'd8);
        check("norm.pulses", 32'({4'(c_dc - s_dc), 4'(c_h - s_h), 4'(c_x - s_x),
                                  4'(c_y - s_y), 4'(c_dn - s_dn)}), 32'h11111);

        // Reset held low for two cycles while in LOAD.
        nb_samples_i = 5; start_i = 1;
        cyc();
        start_i = 0;
        cyc();
        check("rst.in_load", 32'(h_start_o), 32'h1);
        rst_ni = 0;
        cyc();
        check("rst.first.flags", 32'(flags()), 32'h0);
        check("rst.first.cnt", 32'(sample_cnt_o), 32'h0);
        cyc();
        check("rst.second.flags", 32'(flags()), 32'h0);
        rst_ni = 1;
        nb_samples_i = 1; start_i = 1;
        cyc();
        start_i = 0; taps_ready_i = 1;
        cyc();
        cyc();
        taps_ready_i = 0;
        check("rst.rerun_start", 32'({x_start_o, y_start_o}), 32'b11);
        y_valid_i = 1; y_ready_i = 1;
        cyc();
        y_valid_i = 0; y_ready_i = 0; y_done_i = 1;
        check("rst.rerun_cnt", 32'(sample_cnt_o), 32'd1);
        cyc();
        y_done_i = 0;
        check("rst.rerun_done", 32'(done_o), 32'h1);
        cyc();
        check("rst.rerun_idle", 32'(busy_o), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
